// File: rtl/quad_gear_input.sv
// quad_gear_input
// Multi-channel driver-control front end for the arcade cores.
// Each player's digital left/right request becomes a two-phase quadrature
// steering signal stepped at a programmable rate. Each player also gets a
// saturating gear selector that is driven by edge-detected up/down buttons.
//
// Ports:
//   clk_sys      single clock for all logic
//   reset        asynchronous, active-high reset
//   clkdiv       quadrature step period in clk_sys cycles (0 behaves as 1)
//   left/right   per-channel steer requests
//   gearup/down  per-channel shift buttons
//   gear_clr     per-channel synchronous return to gear 0
//   steer_a/b    per-channel quadrature phases A/B
//   gear_onehot  per-channel one-hot gear, NUM_GEARS bits per channel
//   gear_num     per-channel binary gear index, GW bits per channel
module quad_gear_input #(
  parameter int CHANNELS  = 2,
  parameter int DIV_WIDTH = 16,
  parameter int NUM_GEARS = 4,
  localparam int GW       = $clog2(NUM_GEARS)
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          clkdiv,
  input  logic [CHANNELS-1:0]           left,
  input  logic [CHANNELS-1:0]           right,
  input  logic [CHANNELS-1:0]           gearup,
  input  logic [CHANNELS-1:0]           geardown,
  input  logic [CHANNELS-1:0]           gear_clr,
  output logic [CHANNELS-1:0]           steer_a,
  output logic [CHANNELS-1:0]           steer_b,
  output logic [CHANNELS*NUM_GEARS-1:0] gear_onehot,
  output logic [CHANNELS*GW-1:0]        gear_num
);

  localparam logic [GW-1:0] TOP_GEAR = GW'(NUM_GEARS - 1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] cmp_val;
  logic                 tick;

  logic [1:0]           phase_q  [CHANNELS];
  logic [1:0]           phase_d  [CHANNELS];
  logic [GW-1:0]        gear_q   [CHANNELS];
  logic [GW-1:0]        gear_d   [CHANNELS];
  logic [NUM_GEARS-1:0] onehot_q [CHANNELS];
  logic [NUM_GEARS-1:0] onehot_d [CHANNELS];
  logic [CHANNELS-1:0]  up_prev_q, up_prev_d;
  logic [CHANNELS-1:0]  dn_prev_q, dn_prev_d;

  // Shared prescaler. Using >= rather than == means a clkdiv that shrinks
  // below the running count just ticks on the next edge instead of wrapping
  // all the way around the counter.
  always_comb begin
    cmp_val = (clkdiv == '0) ? '0 : clkdiv - DIV_WIDTH'(1);
    tick    = (cnt_q >= cmp_val);
    cnt_d   = tick ? '0 : cnt_q + DIV_WIDTH'(1);
  end

  // Quadrature stepping in Gray order 00->01->11->10 (right) or the reverse
  // (left); conflicting or absent requests hold the phase.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      phase_d[c] = phase_q[c];
      if (tick) begin
        if (right[c] && !left[c]) begin
          phase_d[c] = {phase_q[c][0], ~phase_q[c][1]};
        end else if (left[c] && !right[c]) begin
          phase_d[c] = {~phase_q[c][0], phase_q[c][1]};
        end
      end
    end
  end

  // Gear selector. The button history always follows the buttons, even while
  // gear_clr is masking them, so a button held across a clear never shifts.
  always_comb begin
    up_prev_d = gearup;
    dn_prev_d = geardown;
    for (int c = 0; c < CHANNELS; c++) begin
      gear_d[c] = gear_q[c];
      if (gear_clr[c]) begin
        gear_d[c] = '0;
      end else if ((gearup[c] && !up_prev_q[c]) && (geardown[c] && !dn_prev_q[c])) begin
        gear_d[c] = gear_q[c];
      end else if (gearup[c] && !up_prev_q[c]) begin
        if (gear_q[c] != TOP_GEAR) gear_d[c] = gear_q[c] + GW'(1);
      end else if (geardown[c] && !dn_prev_q[c]) begin
        if (gear_q[c] != '0) gear_d[c] = gear_q[c] - GW'(1);
      end
      for (int g = 0; g < NUM_GEARS; g++) begin
        onehot_d[c][g] = (gear_d[c] == GW'(g));
      end
    end
  end

  // State registers. Button history resets high so that a button already
  // pressed when reset releases is not seen as a fresh press.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      up_prev_q <= '1;
      dn_prev_q <= '1;
      for (int c = 0; c < CHANNELS; c++) begin
        phase_q[c]  <= 2'b00;
        gear_q[c]   <= '0;
        onehot_q[c] <= NUM_GEARS'(1);
      end
    end else begin
      cnt_q     <= cnt_d;
      up_prev_q <= up_prev_d;
      dn_prev_q <= dn_prev_d;
      for (int c = 0; c < CHANNELS; c++) begin
        phase_q[c]  <= phase_d[c];
        gear_q[c]   <= gear_d[c];
        onehot_q[c] <= onehot_d[c];
      end
    end
  end

  // Flatten per-channel registers onto the output buses.
  always_comb begin
    steer_a     = '0;
    steer_b     = '0;
    gear_onehot = '0;
    gear_num    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      steer_a[c]                          = phase_q[c][1];
      steer_b[c]                          = phase_q[c][0];
      gear_onehot[c*NUM_GEARS +: NUM_GEARS] = onehot_q[c];
      gear_num[c*GW +: GW]                = gear_q[c];
    end
  end

endmodule

// File: tb/tb_quad_gear_input.sv
// tb_quad_gear_input
// Drives quad_gear_input with directed sequences followed by random
// stimulus and compares it on every falling edge against a behavioural
// model built from plain integers (step counter, wheel position 0..3, gear).
module tb_quad_gear_input;

  localparam int CH  = 2;
  localparam int DW  = 16;
  localparam int NG  = 4;
  localparam int GW  = $clog2(NG);

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b0;
  logic [DW-1:0]    clkdiv  = '0;
  logic [CH-1:0]    left = '0, right = '0, gearup = '0, geardown = '0, gear_clr = '0;
  logic [CH-1:0]    steer_a, steer_b;
  logic [CH*NG-1:0] gear_onehot;
  logic [CH*GW-1:0] gear_num;

  int compared   = 0;
  int mismatched = 0;
  bit armed      = 1'b0;

  quad_gear_input #(.CHANNELS(CH), .DIV_WIDTH(DW), .NUM_GEARS(NG)) dut (
    .clk_sys(clk_sys), .reset(reset), .clkdiv(clkdiv),
    .left(left), .right(right), .gearup(gearup), .geardown(geardown),
    .gear_clr(gear_clr), .steer_a(steer_a), .steer_b(steer_b),
    .gear_onehot(gear_onehot), .gear_num(gear_num)
  );

  always #5 clk_sys = ~clk_sys;

  // Behavioural model: wheel position index 0..3 maps onto the Gray code.
  int m_cnt;
  int m_pos  [CH];
  int m_gear [CH];
  bit m_up_prev [CH];
  bit m_dn_prev [CH];
  int m_cmp;
  bit m_tick, m_up, m_dn;

  function automatic logic [1:0] pos_code(input int p);
    case (p)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      m_cnt = 0;
      for (int c = 0; c < CH; c++) begin
        m_pos[c] = 0; m_gear[c] = 0; m_up_prev[c] = 1; m_dn_prev[c] = 1;
      end
    end else begin
      m_cmp  = (clkdiv == 0) ? 0 : int'(clkdiv) - 1;
      m_tick = (m_cnt >= m_cmp);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      for (int c = 0; c < CH; c++) begin
        if (m_tick && right[c] && !left[c]) m_pos[c] = (m_pos[c] + 1) % 4;
        if (m_tick && left[c] && !right[c]) m_pos[c] = (m_pos[c] + 3) % 4;
        m_up = gearup[c] && !m_up_prev[c];
        m_dn = geardown[c] && !m_dn_prev[c];
        if (gear_clr[c]) m_gear[c] = 0;
        else if (m_up && m_dn) m_gear[c] = m_gear[c];
        else if (m_up) m_gear[c] = (m_gear[c] + 1 > NG - 1) ? NG - 1 : m_gear[c] + 1;
        else if (m_dn) m_gear[c] = (m_gear[c] - 1 < 0) ? 0 : m_gear[c] - 1;
        m_up_prev[c] = gearup[c];
        m_dn_prev[c] = geardown[c];
      end
    end
  end

  function automatic int steer_of(input int c);
    return int'({steer_a[c], steer_b[c]});
  endfunction

  function automatic int gear_of(input int c);
    return int'(gear_num[c*GW +: GW]);
  endfunction

  function automatic int onehot_of(input int c);
    return int'(gear_onehot[c*NG +: NG]);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge once the first reset has happened.
  always @(negedge clk_sys) begin
    if (armed) begin
      for (int c = 0; c < CH; c++) begin
        checkOutput($sformatf("model_steer_ch%0d", c), steer_of(c), int'(pos_code(m_pos[c])));
        checkOutput($sformatf("model_gear_ch%0d", c), gear_of(c), m_gear[c]);
        checkOutput($sformatf("model_onehot_ch%0d", c), onehot_of(c), 1 << m_gear[c]);
      end
    end
  end

  task automatic gearPulse(input bit up, input int c);
    if (up) gearup[c] = 1'b1; else geardown[c] = 1'b1;
    @(negedge clk_sys);
    if (up) gearup[c] = 1'b0; else geardown[c] = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic applyStimulus();
    int up_exp [5] = '{1, 2, 3, 3, 3};
    int dn_exp [5] = '{2, 1, 0, 0, 0};

    // Reset state
    clkdiv = 16'd4;
    #1 reset = 1'b1;
    armed = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    checkOutput("reset_steer_ch0", steer_of(0), 0);
    checkOutput("reset_steer_ch1", steer_of(1), 0);
    checkOutput("reset_gear_num", int'(gear_num), 0);
    checkOutput("reset_onehot", int'(gear_onehot), 8'b0001_0001);

    // clkdiv=4, right on channel 0: ticks at edges 4, 8, 12, 16
    right = 2'b01;
    reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk_sys);
      if (e == 3)  checkOutput("div4_edge3", steer_of(0), 2'b00);
      if (e == 4)  checkOutput("div4_edge4", steer_of(0), 2'b01);
      if (e == 8)  checkOutput("div4_edge8", steer_of(0), 2'b11);
      if (e == 12) checkOutput("div4_edge12", steer_of(0), 2'b10);
      if (e == 16) checkOutput("div4_edge16", steer_of(0), 2'b00);
      if (e == 16) checkOutput("div4_ch1_idle", steer_of(1), 2'b00);
    end

    // clkdiv=0 steps every cycle; left on channel 1 runs in reverse order
    clkdiv = '0;
    right  = 2'b00;
    left   = 2'b10;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk_sys);
      case (e)
        1: checkOutput("div0_left_1", steer_of(1), 2'b10);
        2: checkOutput("div0_left_2", steer_of(1), 2'b11);
        3: checkOutput("div0_left_3", steer_of(1), 2'b01);
        default: checkOutput("div0_left_4", steer_of(1), 2'b00);
      endcase
    end
    left = 2'b11;
    right = 2'b11;
    repeat (3) @(negedge clk_sys);
    checkOutput("both_frozen_ch1", steer_of(1), 2'b00);
    checkOutput("both_frozen_ch0", steer_of(0), 2'b00);
    left = '0;
    right = '0;

    // Gear saturation both ways
    for (int i = 0; i < 5; i++) begin
      gearPulse(1'b1, 0);
      checkOutput($sformatf("gearup_pulse%0d", i), gear_of(0), up_exp[i]);
      checkOutput($sformatf("gearup_onehot%0d", i), onehot_of(0), 1 << up_exp[i]);
    end
    for (int i = 0; i < 5; i++) begin
      gearPulse(1'b0, 0);
      checkOutput($sformatf("geardn_pulse%0d", i), gear_of(0), dn_exp[i]);
    end

    // Held button shifts once; simultaneous edges hold; clear beats an edge
    gearup[0] = 1'b1;
    repeat (20) @(negedge clk_sys);
    gearup[0] = 1'b0;
    @(negedge clk_sys);
    checkOutput("held_once", gear_of(0), 1);
    gearup[0] = 1'b1;
    geardown[0] = 1'b1;
    @(negedge clk_sys);
    checkOutput("both_edges_hold", gear_of(0), 1);
    gearup[0] = 1'b0;
    geardown[0] = 1'b0;
    @(negedge clk_sys);
    gearup[0] = 1'b1;
    gear_clr[0] = 1'b1;
    @(negedge clk_sys);
    checkOutput("clr_beats_up", gear_of(0), 0);
    gear_clr[0] = 1'b0;
    @(negedge clk_sys);
    checkOutput("clr_release_held", gear_of(0), 0);

    // Button held across reset release does not shift; re-press does
    #2 reset = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("held_through_reset", gear_of(0), 0);
    gearup[0] = 1'b0;
    @(negedge clk_sys);
    gearup[0] = 1'b1;
    @(negedge clk_sys);
    checkOutput("repress_after_reset", gear_of(0), 1);
    gearup[0] = 1'b0;

    // clkdiv shrinks from 20 to 3 while count is 9, then async reset
    #2 reset = 1'b1;
    clkdiv = 16'd20;
    right = 2'b01;
    @(negedge clk_sys);
    #2 reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk_sys);
      if (e == 2) gearup[1] = 1'b1;
      if (e == 5) gearup[1] = 1'b0;
      if (e == 9) begin
        checkOutput("shrink_edge9", steer_of(0), 2'b00);
        clkdiv = 16'd3;
      end
      if (e == 10) checkOutput("shrink_edge10", steer_of(0), 2'b01);
      if (e == 12) checkOutput("shrink_edge12", steer_of(0), 2'b01);
      if (e == 13) checkOutput("shrink_edge13", steer_of(0), 2'b11);
      if (e == 16) checkOutput("shrink_edge16", steer_of(0), 2'b10);
      if (e == 16) checkOutput("ch1_gear_before_reset", gear_of(1), 1);
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_steer", steer_of(0), 0);
    checkOutput("async_reset_gear", gear_of(1), 0);
    checkOutput("async_reset_onehot", onehot_of(1), 1);
    @(negedge clk_sys);
    #2 reset = 1'b0;

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      if ($urandom_range(0, 49) == 0) clkdiv = DW'($urandom_range(0, 7));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) left[c] = ~left[c];
        if ($urandom_range(0, 7) == 0) right[c] = ~right[c];
        if ($urandom_range(0, 3) == 0) gearup[c] = ~gearup[c];
        if ($urandom_range(0, 3) == 0) geardown[c] = ~geardown[c];
        gear_clr[c] = ($urandom_range(0, 39) == 0);
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk_sys);
        #2 reset = 1'b0;
      end
    end
  endtask

  initial begin
    applyStimulus();
    @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/quad_gear_input.md
# quad_gear_input

Parametrised, multi-channel driver-control front end for the arcade cores. It converts each player's digital left/right inputs into a two-phase quadrature steering signal at a programmable rate, and it keeps a saturating N-position gear selector driven by edge-detected up/down requests. It sits between the hps_io joystick/keyboard mapping and the game core's steering-encoder and gear-switch inputs. It generalises single-channel steering and fixed three-gear shifting to CHANNELS players and NUM_GEARS positions.

## Interface
Parameters:
- CHANNELS, 2 — number of independent player channels (≥1)
- DIV_WIDTH, 16 — width of the step-period input
- NUM_GEARS, 4 — gear positions per channel (≥2); GW = $clog2(NUM_GEARS)

Ports:
- clk_sys  in  1  — single clock domain for all logic
- reset  in  1  — asynchronous, active-high reset
- clkdiv  in  DIV_WIDTH  — quadrature step period in clk_sys cycles; 0 is treated as 1
- left  in  CHANNELS  — per-channel steer-left request, active high
- right  in  CHANNELS  — per-channel steer-right request, active high
- gearup  in  CHANNELS  — per-channel shift-up button, active high
- geardown  in  CHANNELS  — per-channel shift-down button, active high
- gear_clr  in  CHANNELS  — synchronous per-channel return to gear 0 (e.g. start button)
- steer_a  out  CHANNELS  — quadrature phase A
- steer_b  out  CHANNELS  — quadrature phase B
- gear_onehot  out  CHANNELS*NUM_GEARS  — one-hot gear; channel c occupies bits [c*NUM_GEARS +: NUM_GEARS]
- gear_num  out  CHANNELS*GW  — binary gear index; channel c occupies bits [c*GW +: GW]

## Operation
Reset (async assert) sets:
- prescaler = 0
- every phase register = 2'b00, so steer_a = steer_b = 0
- every gear = 0, so gear_onehot channel word = 1 and gear_num = 0
- edge-history registers for gearup/geardown = all 1s, so a button held through reset release does not shift

Prescaler (shared by all channels):
- Counts clk_sys. The compare value is max(clkdiv,1) − 1.
- When count ≥ compare: tick = 1 and count ← 0. Otherwise count ← count + 1.
- If clkdiv shrinks below the current count, the next edge ticks and wraps. It never runs away.

Quadrature (per channel, on a tick only):
- right=1, left=0: phase advances 00→01→11→10→00.
- left=1, right=0: phase steps in the reverse order.
- Both or neither asserted: phase holds.
- steer_a = phase[1], steer_b = phase[0]. Exactly one output bit changes per step.

Gear selector (per channel, every clk_sys edge):
- up_edge = gearup & ~gearup_prev; dn_edge = geardown & ~geardown_prev. The history registers update every cycle.
- Priority order:
  1. gear_clr → gear 0.
  2. up_edge & dn_edge → hold.
  3. up_edge → gear+1, saturating at NUM_GEARS−1.
  4. dn_edge → gear−1, saturating at 0.
  5. Otherwise → hold.
- gear_onehot = 1 << gear. gear_num = gear.
- A held button shifts exactly once. No auto-repeat.
- gear_clr held continuously pins gear 0 and masks all edges. The edge history still updates, so releasing gear_clr while a button is held causes no shift.

Channels are fully independent except for the shared prescaler tick.

## Timing
- All outputs come directly from registers. No combinational paths from input to output.
- Steering latency: left/right sampled at a tick edge; the new phase is visible immediately after that edge. One phase step per tick, so the quadrature period is 4·max(clkdiv,1) cycles.
- Gear latency: a button rising at edge k updates gear at edge k; outputs are valid after edge k. The button must be low for at least one sampled cycle to re-arm.
- Reset mid-operation: all state returns to reset values asynchronously. The first tick after release occurs max(clkdiv,1) edges later.

## Test plan
- Reset, clkdiv=4, right[0]=1 held for 16 cycles → ticks at edges 4,8,12,16; (steer_a,steer_b) = 01,11,10,00. Channel 1 stays 00.
- clkdiv=0, left[1]=1 → phase steps every cycle in the order 10,11,01,00. left=right=1 → phase frozen.
- NUM_GEARS=4: five separate gearup pulses → gear_num 1,2,3,3,3; gear_onehot 0010,0100,1000,1000,1000. Five geardown pulses → gear_num saturates at 0.
- gearup held 20 cycles → exactly one increment. gearup and geardown rising on the same edge → no change. gear_clr together with gearup edge → gear 0.
- gearup held high across reset release → gear stays 0. Release then re-press → gear 1.
- Counter at 9 with clkdiv=20, clkdiv changed to 3 → tick on the next edge, then every 3 cycles. Async reset asserted mid-step → outputs go to 0 and gear to 0 with no clock edge.
